digiota_cmp_decimator: RTL and testbench
========================================

Name: digiota_cmp_decimator

Overview:
- Downstream consumer of the DigiOTA comparator output bit.
- Synchronises the asynchronous comparator decision into clk and rejects single-sample glitches with a 3-tap majority filter.
- Counts filtered ones over a fixed window of 2^WIN_LOG2 enabled samples, giving a density/duty-cycle estimate of Vip > Vin.
- Results are delivered through a valid/ready handshake with overrun detection.

Parameters:
- SYNC_STAGES, 2, number of flops in the cmp_in synchroniser chain (minimum 2).
- WIN_LOG2, 8, log2 of the window length in enabled samples (window = 256 by default).
- OUT_W, WIN_LOG2+1, result width; holds 0..2^WIN_LOG2 inclusive.

Ports:
- clk, input, 1, single design clock.
- rst_n, input, 1, asynchronous active-low reset.
- cmp_in, input, 1, raw comparator output, asynchronous to clk.
- en, input, 1, sample enable; window advances only on cycles with en=1.
- clr, input, 1, synchronous clear of window, filter and handshake state.
- result_ready, input, 1, consumer accepts result when high while result_valid=1.
- result, output, OUT_W, ones count of the last completed window.
- result_valid, output, 1, result holds unconsumed data.
- overrun, output, 1, sticky: a completed window overwrote an unconsumed result.
- cmp_filt, output, 1, synchronised, majority-filtered comparator bit.

Behaviour:
- Reset: asynchronous, active-low rst_n. It clears the sync chain, filter taps, sample counter, accumulator, result, result_valid and overrun to 0. All outputs read 0 during reset and on the first edge after release.
- Synchroniser:
  - A SYNC_STAGES-flop chain runs every cycle, independent of en and clr.
  - Its output is s.
- Filter:
  - 3-tap shift register t0<=s, t1<=t0, t2<=t1, updated only when en=1.
  - cmp_filt = majority(t0,t1,t2), combinational from the taps.
  - Latency with en held high: a cmp_in step appears on cmp_filt after SYNC_STAGES+2 rising edges.
  - Any isolated 1-sample pulse is suppressed.
- Window:
  - sample_cnt (WIN_LOG2 bits) and acc (OUT_W bits) update on en=1 cycles only.
  - Each en cycle: acc += cmp_filt and sample_cnt++.
  - When sample_cnt == 2^WIN_LOG2-1 with en=1:
    - result <= acc + cmp_filt;
    - result_valid <= 1;
    - acc <= 0 and sample_cnt <= 0, wrapping naturally.
  - Result is visible the cycle after the 2^WIN_LOG2-th enabled sample.
  - en=0 pauses the window; it does not restart it.
- Handshake:
  - result_valid && result_ready on an edge clears result_valid, unless a window completes on the same edge.
  - If a window completes on the same edge as acceptance: the new result loads, result_valid stays 1, overrun is unchanged.
  - If a window completes while result_valid=1 and result_ready=0: result is overwritten, result_valid stays 1, overrun <= 1.
  - result is stable while result_valid=1 and no window completes.
  - result_ready with result_valid=0 is ignored.
- overrun: sticky; cleared only by rst_n or clr.
- clr:
  - Synchronous; has priority over en, window completion and handshake.
  - Clears taps, sample_cnt, acc, result, result_valid and overrun.
  - The sync chain is untouched.
  - The first enabled sample after clr starts a fresh window.
- Mid-operation reset: an in-progress window is discarded with no partial result.
- Arithmetic: acc never exceeds 2^WIN_LOG2, so no saturation logic is needed; OUT_W must not be reduced below WIN_LOG2+1.

Test Plan:
- Bench uses WIN_LOG2=4 and SYNC_STAGES=2 for all scenarios.
- Constant one: cmp_in=1, en=1 from reset release.
  - Expected: the first window reads the filter fill as zeros, so result=13.
  - Expected: the second window reports result=16 with a result_valid pulse.
  - result_ready held high; overrun stays 0.
- Alternating and glitch rejection:
  - cmp_in toggling every cycle for 3 windows → every window after the first reports result=8.
  - cmp_in=0 with one 1-cycle high pulse per window → cmp_filt never rises; result=0.
- Step latency: cmp_in 0→1 at edge N with en=1 → cmp_filt rises after edge N+4. With en=0 during edges N..N+10, cmp_filt stays 0.
- Overrun and simultaneous events:
  - result_ready=0 across two complete windows of constant 1 → after the second window, result=16, result_valid=1, overrun=1.
  - result_ready=1 on exactly the completion edge → new result loads, result_valid stays 1, overrun stays 0.
- clr and reset mid-window:
  - clr after 7 samples of constant 1 → result_valid=0 and overrun=0. The next window is measured from 16 fresh enabled samples and reports result=14 (2-sample filter refill).
  - rst_n pulsed low mid-window → all outputs 0 immediately, with no stale result afterwards.

Source files
------------

// File: rtl/digiota_cmp_decimator.sv
// digiota_cmp_decimator: synchronises the DigiOTA comparator bit, majority-filters it and
// reports the count of filtered ones over each window of 2^WIN_LOG2 enabled samples through
// a valid/ready handshake with a sticky overrun flag.
module digiota_cmp_decimator #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WIN_LOG2    = 8,
    parameter int unsigned OUT_W       = WIN_LOG2 + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmp_in,
    input  logic             en,
    input  logic             clr,
    input  logic             result_ready,
    output logic [OUT_W-1:0] result,
    output logic             result_valid,
    output logic             overrun,
    output logic             cmp_filt
);

    // Synchroniser chain; bit 0 captures the asynchronous comparator output.
    logic [SYNC_STAGES-1:0] r_sync;
    // Filter taps: bit 0 is the newest synchronised sample.
    logic [2:0]             r_taps;
    logic [WIN_LOG2-1:0]    r_cnt;
    logic [OUT_W-1:0]       r_acc;
    logic [OUT_W-1:0]       r_result;
    logic                   r_valid;
    logic                   r_overrun;

    logic                   w_sync_out;
    logic                   w_filt;
    logic                   w_last;
    logic [OUT_W-1:0]       w_sum;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_filt     = (r_taps[0] & r_taps[1]) | (r_taps[0] & r_taps[2])
                      | (r_taps[1] & r_taps[2]);
    // Window closes on the enabled sample that takes the counter through its top value.
    assign w_last     = en & (r_cnt == '1);
    // Includes the sample being taken this cycle so the closing sample lands in the result.
    assign w_sum      = r_acc + {{(OUT_W-1){1'b0}}, w_filt};

    assign result       = r_result;
    assign result_valid = r_valid;
    assign overrun      = r_overrun;
    assign cmp_filt     = w_filt;

    // Synchroniser runs every cycle; clr and en deliberately do not touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], cmp_in};
        end
    end

    // Filter taps shift only on enabled samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taps <= '0;
        end else if (clr) begin
            r_taps <= '0;
        end else if (en) begin
            r_taps <= {r_taps[1:0], w_sync_out};
        end
    end

    // Window sample counter and ones accumulator; en=0 pauses without restarting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (clr) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + WIN_LOG2'(1);
            r_acc <= w_last ? '0 : w_sum;
        end
    end

    // Result register and handshake; a completing window wins over a same-edge acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (clr) begin
            r_result  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_last) begin
            r_result <= w_sum;
            r_valid  <= 1'b1;
            if (r_valid && !result_ready) begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && result_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_digiota_cmp_decimator.sv
// Bench for digiota_cmp_decimator: randomised and directed stimulus compared every cycle
// against a sample-history model, plus directed checks of the documented scenarios.
module tb_digiota_cmp_decimator;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned WIN_LOG2    = 4;
    localparam int unsigned OUT_W       = WIN_LOG2 + 1;
    localparam int          WIN         = 1 << WIN_LOG2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmp_in;
    logic             en;
    logic             clr;
    logic             result_ready;
    logic [OUT_W-1:0] result;
    logic             result_valid;
    logic             overrun;
    logic             cmp_filt;

    int checks   = 0;
    int failures = 0;

    // Reference model state: recent raw samples, recent filter inputs, window tallies.
    bit m_sync_q[$];
    bit m_taps_q[$];
    int m_n;
    int m_ones;
    int m_result;
    bit m_valid;
    bit m_over;

    digiota_cmp_decimator #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIN_LOG2    (WIN_LOG2),
        .OUT_W       (OUT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmp_in       (cmp_in),
        .en           (en),
        .clr          (clr),
        .result_ready (result_ready),
        .result       (result),
        .result_valid (result_valid),
        .overrun      (overrun),
        .cmp_filt     (cmp_filt)
    );

    always #5 clk = ~clk;

    function automatic bit m_filt();
        int ones = 0;
        foreach (m_taps_q[i]) ones += int'(m_taps_q[i]);
        return ones >= 2;
    endfunction

    task automatic clear_taps();
        m_taps_q = {};
        repeat (3) m_taps_q.push_back(1'b0);
    endtask

    task automatic model_reset();
        m_sync_q = {};
        repeat (SYNC_STAGES) m_sync_q.push_back(1'b0);
        clear_taps();
        m_n      = 0;
        m_ones   = 0;
        m_result = 0;
        m_valid  = 1'b0;
        m_over   = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs held across that edge.
    task automatic model_edge();
        bit s;
        bit f;
        bit done;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s    = m_sync_q[$];
        f    = m_filt();
        done = 1'b0;
        m_sync_q.push_front(cmp_in);
        void'(m_sync_q.pop_back());
        if (clr) begin
            clear_taps();
            m_n      = 0;
            m_ones   = 0;
            m_result = 0;
            m_valid  = 1'b0;
            m_over   = 1'b0;
        end else begin
            if (en) begin
                m_taps_q.push_front(s);
                void'(m_taps_q.pop_back());
                m_ones += int'(f);
                m_n++;
                if (m_n == WIN) done = 1'b1;
            end
            if (done) begin
                if (m_valid && !result_ready) m_over = 1'b1;
                m_result = m_ones;
                m_valid  = 1'b1;
                m_ones   = 0;
                m_n      = 0;
            end else if (m_valid && result_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("result", 32'(result), 32'(m_result));
        chk("result_valid", 32'(result_valid), 32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_over));
        chk("cmp_filt", 32'(cmp_filt), 32'(m_filt()));
    endtask

    // One clock: model follows the edge, outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_random(input int n);
        repeat (n) begin
            cmp_in       = 1'($urandom);
            en           = ($urandom_range(0, 3) != 0);
            result_ready = 1'($urandom);
            clr          = ($urandom_range(0, 40) == 0);
            tick();
        end
        clr = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        cmp_in       = 1'b1;
        en           = 1'b0;
        clr          = 1'b0;
        result_ready = 1'b1;
        model_reset();

        // Reset state.
        #2;
        chk("rst_result", 32'(result), 0);
        chk("rst_valid", 32'(result_valid), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_filt", 32'(cmp_filt), 0);
        run(2);

        // Constant one; the first edge after release only primes the synchroniser.
        rst_n = 1'b1;
        tick();
        chk("first_edge_result", 32'(result), 0);
        chk("first_edge_valid", 32'(result_valid), 0);
        chk("first_edge_filt", 32'(cmp_filt), 0);
        en = 1'b1;
        run(WIN);
        chk("const1_w1", 32'(result), 13);
        chk("const1_w1_valid", 32'(result_valid), 1);
        run(WIN);
        chk("const1_w2", 32'(result), 16);
        chk("const1_w2_valid", 32'(result_valid), 1);
        tick();
        chk("const1_valid_pulse", 32'(result_valid), 0);
        chk("const1_overrun", 32'(overrun), 0);

        // Alternating input: steady windows count half ones.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < WIN; i++) begin
                cmp_in = ~cmp_in;
                tick();
            end
            if (w > 0) chk("alt_window", 32'(result), 8);
        end

        // Single-sample glitches never reach the filter output.
        cmp_in = 1'b0;
        en     = 1'b0;
        run(3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 2 * WIN; i++) begin
            cmp_in = (i == 4) || (i == 20);
            tick();
            chk("glitch_filt", 32'(cmp_filt), 0);
        end
        chk("glitch_result", 32'(result), 0);

        // Step latency with en high: rises on the fourth edge that sees the step.
        cmp_in = 1'b0;
        run(4);
        cmp_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("step_latency", 32'(cmp_filt), (i == 4) ? 1 : 0);
        end

        // Step with en low: filter is frozen.
        cmp_in = 1'b0;
        run(5);
        en     = 1'b0;
        cmp_in = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            chk("step_en_low", 32'(cmp_filt), 0);
        end
        en = 1'b1;
        run(4);
        chk("step_resume", 32'(cmp_filt), 1);

        // Overrun: two windows with nobody accepting.
        result_ready = 1'b0;
        clr          = 1'b1;
        tick();
        clr = 1'b0;
        run(WIN);
        chk("ovr_w1_result", 32'(result), 14);
        chk("ovr_w1_overrun", 32'(overrun), 0);
        run(WIN);
        chk("ovr_w2_result", 32'(result), 16);
        chk("ovr_w2_valid", 32'(result_valid), 1);
        chk("ovr_w2_overrun", 32'(overrun), 1);

        // Acceptance on exactly the completion edge.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        run(2 * WIN - 1);
        result_ready = 1'b1;
        tick();
        chk("simul_result", 32'(result), 16);
        chk("simul_valid", 32'(result_valid), 1);
        chk("simul_overrun", 32'(overrun), 0);
        tick();
        chk("simul_after_valid", 32'(result_valid), 0);

        // clr mid-window after an overrun has been flagged.
        result_ready = 1'b0;
        clr          = 1'b1;
        tick();
        clr = 1'b0;
        run(2 * WIN + 7);
        chk("pre_clr_overrun", 32'(overrun), 1);
        clr = 1'b1;
        tick();
        chk("clr_valid", 32'(result_valid), 0);
        chk("clr_overrun", 32'(overrun), 0);
        chk("clr_result", 32'(result), 0);
        clr          = 1'b0;
        result_ready = 1'b1;
        run(WIN - 1);
        chk("clr_no_early_valid", 32'(result_valid), 0);
        tick();
        chk("clr_fresh_result", 32'(result), 14);
        chk("clr_fresh_valid", 32'(result_valid), 1);

        // Reset mid-window: outputs drop at once, no stale result afterwards.
        run(5);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_result", 32'(result), 0);
        chk("rst_mid_valid", 32'(result_valid), 0);
        chk("rst_mid_overrun", 32'(overrun), 0);
        chk("rst_mid_filt", 32'(cmp_filt), 0);
        run(2);
        rst_n = 1'b1;
        run(WIN - 1);
        chk("rst_no_stale", 32'(result_valid), 0);
        tick();
        chk("rst_fresh_result", 32'(result), 12);

        // Randomised traffic against the model.
        run_random(600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
